alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// MIPS-style execute unit: single-cycle ALU ops plus a 32-iteration iterative multiply/divide sharing HI/LO.
// Results are registered and held until the consumer accepts them.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  alu_op,
  input  logic [4:0]  shamt,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  output logic        illegal,
  output logic        busy
);

  localparam logic [5:0] OP_SLL   = 6'h00;
  localparam logic [5:0] OP_SRL   = 6'h02;
  localparam logic [5:0] OP_SRA   = 6'h03;
  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MFLO  = 6'h12;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;
  localparam logic [5:0] OP_ADD   = 6'h20;
  localparam logic [5:0] OP_ADDU  = 6'h21;
  localparam logic [5:0] OP_SUB   = 6'h22;
  localparam logic [5:0] OP_SUBU  = 6'h23;
  localparam logic [5:0] OP_AND   = 6'h24;
  localparam logic [5:0] OP_OR    = 6'h25;
  localparam logic [5:0] OP_XOR   = 6'h26;
  localparam logic [5:0] OP_NOR   = 6'h27;
  localparam logic [5:0] OP_SLT   = 6'h2A;
  localparam logic [5:0] OP_SLTU  = 6'h2B;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] work_q, work_d;
  logic [31:0] opnd_q, opnd_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;
  logic        ill_q, ill_d;

  logic        accept;
  logic [31:0] add_res, sub_res;
  logic [31:0] sc_res, sc_hi, sc_lo;
  logic        sc_ovf, sc_ill;
  logic        signed_op, start_mul, start_div;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [32:0] div_rs;
  logic        div_ge;
  logic [31:0] step_acc, step_work;
  logic [63:0] prod_s;
  logic [31:0] fin_hi, fin_lo;

  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign busy      = (state_q != S_IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;

  assign add_res   = a + b;
  assign sub_res   = a - b;
  assign signed_op = (alu_op == OP_MULT) || (alu_op == OP_DIV);
  assign start_mul = (alu_op == OP_MULT) || (alu_op == OP_MULTU);
  assign start_div = ((alu_op == OP_DIV) || (alu_op == OP_DIVU)) && (b != 32'd0);
  assign abs_a     = (signed_op && a[31]) ? -a : a;
  assign abs_b     = (signed_op && b[31]) ? -b : b;

  always_comb begin
    sc_res = 32'd0;
    sc_ovf = 1'b0;
    sc_ill = 1'b0;
    sc_hi  = hi_q;
    sc_lo  = lo_q;
    case (alu_op)
      OP_SLL:  sc_res = b << shamt;
      OP_SRL:  sc_res = b >> shamt;
      OP_SRA:  sc_res = $signed(b) >>> shamt;
      OP_MFHI: sc_res = hi_q;
      OP_MFLO: sc_res = lo_q;
      OP_MULT, OP_MULTU: sc_res = 32'd0;
      // Only reached single-cycle when the divisor is zero.
      OP_DIV, OP_DIVU: begin
        sc_res = 32'hFFFF_FFFF;
        sc_hi  = a;
        sc_lo  = 32'hFFFF_FFFF;
      end
      OP_ADD: begin
        sc_res = add_res;
        sc_ovf = (a[31] == b[31]) && (add_res[31] != a[31]);
      end
      OP_ADDU: sc_res = add_res;
      OP_SUB: begin
        sc_res = sub_res;
        sc_ovf = (a[31] != b[31]) && (sub_res[31] != a[31]);
      end
      OP_SUBU: sc_res = sub_res;
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      OP_SLT:  sc_res = {31'd0, ($signed(a) < $signed(b))};
      OP_SLTU: sc_res = {31'd0, (a < b)};
      default: sc_ill = 1'b1;
    endcase
  end

  // One iteration: shift-add for MUL ({acc,work} is the product), restoring step for DIV (acc=rem, work=quot).
  assign mul_sum = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign div_rs  = {acc_q, work_q[31]};
  assign div_ge  = (div_rs >= {1'b0, opnd_q});

  always_comb begin
    step_acc  = acc_q;
    step_work = work_q;
    prod_s    = 64'd0;
    fin_hi    = 32'd0;
    fin_lo    = 32'd0;
    if (state_q == S_MUL) begin
      step_acc  = mul_sum[32:1];
      step_work = {mul_sum[0], work_q[31:1]};
      prod_s    = qneg_q ? -{step_acc, step_work} : {step_acc, step_work};
      fin_hi    = prod_s[63:32];
      fin_lo    = prod_s[31:0];
    end else if (state_q == S_DIV) begin
      step_acc  = div_ge ? (div_rs[31:0] - opnd_q) : div_rs[31:0];
      step_work = {work_q[30:0], div_ge};
      fin_lo    = qneg_q ? -step_work : step_work;
      fin_hi    = rneg_q ? -step_acc : step_acc;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    work_d      = work_q;
    opnd_d      = opnd_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    ill_d       = ill_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (start_mul || start_div) begin
            state_d = start_mul ? S_MUL : S_DIV;
            cnt_d   = 5'd0;
            acc_d   = 32'd0;
            qneg_d  = signed_op && (a[31] ^ b[31]);
            rneg_d  = signed_op && a[31];
            work_d  = start_mul ? abs_b : abs_a;
            opnd_d  = start_mul ? abs_a : abs_b;
          end else begin
            out_valid_d = 1'b1;
            result_d    = sc_res;
            zero_d      = (sc_res == 32'd0);
            ovf_d       = sc_ovf;
            ill_d       = sc_ill;
            hi_d        = sc_hi;
            lo_d        = sc_lo;
          end
        end
      end
      S_MUL, S_DIV: begin
        acc_d  = step_acc;
        work_d = step_work;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d     = S_IDLE;
          cnt_d       = 5'd0;
          hi_d        = fin_hi;
          lo_d        = fin_lo;
          out_valid_d = 1'b1;
          result_d    = fin_lo;
          zero_d      = (fin_lo == 32'd0);
          ovf_d       = 1'b0;
          ill_d       = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      acc_q       <= 32'd0;
      work_q      <= 32'd0;
      opnd_q      <= 32'd0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      work_q      <= work_d;
      opnd_q      <= opnd_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: driver pushes hand-computed expectations, monitor pops and compares on output.
module tb_alu_exec_unit;

  localparam logic [5:0] OP_SLL = 6'h00, OP_SRL = 6'h02, OP_SRA = 6'h03;
  localparam logic [5:0] OP_MFHI = 6'h10, OP_MFLO = 6'h12;
  localparam logic [5:0] OP_MULT = 6'h18, OP_MULTU = 6'h19, OP_DIV = 6'h1A, OP_DIVU = 6'h1B;
  localparam logic [5:0] OP_ADD = 6'h20, OP_ADDU = 6'h21, OP_SUB = 6'h22, OP_SUBU = 6'h23;
  localparam logic [5:0] OP_AND = 6'h24, OP_OR = 6'h25, OP_XOR = 6'h26, OP_NOR = 6'h27;
  localparam logic [5:0] OP_SLT = 6'h2A, OP_SLTU = 6'h2B;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  alu_op;
  logic [4:0]  shamt;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, overflow, illegal, busy;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .shamt(shamt), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .illegal(illegal), .busy(busy)
  );

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;   // {zero, overflow, illegal}
    int          cyc;     // cycle count at which out_valid must first appear
  } exp_t;

  exp_t sbq[$];
  bit   seen = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares the presented output every cycle it is valid, so held values are checked too.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result 0x%08h, expected no output", result);
      end else begin
        if (!seen) begin
          chk("latency_cycle", 32'(cyc), 32'(sbq[0].cyc));
          seen = 1'b1;
        end
        chk("result", result, sbq[0].res);
        chk("flags_zero_ovf_ill", {29'd0, zero, overflow, illegal}, {29'd0, sbq[0].flags});
      end
    end
  end

  // Transfer is decided on the edge itself, with pre-edge values.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready && sbq.size() != 0) begin
      void'(sbq.pop_front());
      seen = 1'b0;
    end
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [4:0] sh, input logic [31:0] eres, input logic eovf,
                       input logic eill, input int lat);
    exp_t e;
    int   w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      in_valid = 1'b0;
      $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", w);
    end else begin
      alu_op   = op;
      a        = aa;
      b        = bb;
      shamt    = sh;
      in_valid = 1'b1;
      e.res    = eres;
      e.flags  = {(eres == 32'd0), eovf, eill};
      e.cyc    = cyc + 1 + lat;
      sbq.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic drop();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sbq.size());
      sbq.delete();
      seen = 1'b0;
    end
  endtask

  initial begin
    bit ok;
    rst       = 1'b1;
    in_valid  = 1'b1;
    alu_op    = OP_ADD;
    a         = 32'd1;
    b         = 32'd2;
    shamt     = 5'd0;
    out_ready = 1'b1;

    // Reset state, with a request held during reset that must not be taken.
    repeat (3) @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {29'd0, zero, overflow, illegal}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("no_accept_during_reset", {31'd0, out_valid}, 32'd0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back single-cycle ops: each must appear exactly one cycle after its accept.
    issue(OP_MFLO, 32'h0,        32'h0,        5'd0,  32'h0000_0000, 1'b0, 1'b0, 0);
    issue(OP_ADD,  32'h7FFF_FFFF, 32'h1,       5'd0,  32'h8000_0000, 1'b1, 1'b0, 0);
    issue(OP_ADDU, 32'h7FFF_FFFF, 32'h1,       5'd0,  32'h8000_0000, 1'b0, 1'b0, 0);
    issue(OP_ADD,  32'h8000_0000, 32'h8000_0000, 5'd0, 32'h0000_0000, 1'b1, 1'b0, 0);
    issue(OP_SUB,  32'h8000_0000, 32'h1,       5'd0,  32'h7FFF_FFFF, 1'b1, 1'b0, 0);
    issue(OP_SUBU, 32'h5,        32'h7,        5'd0,  32'hFFFF_FFFE, 1'b0, 1'b0, 0);
    issue(OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b0, 1'b0, 0);
    issue(OP_OR,   32'h0000_000F, 32'h0000_00F0, 5'd0, 32'h0000_00FF, 1'b0, 1'b0, 0);
    issue(OP_XOR,  32'h1234_5678, 32'h1234_5678, 5'd0, 32'h0000_0000, 1'b0, 1'b0, 0);
    issue(OP_NOR,  32'h0,        32'h0,        5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    issue(OP_SLT,  32'hFFFF_FFFF, 32'h1,       5'd0,  32'h0000_0001, 1'b0, 1'b0, 0);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1,       5'd0,  32'h0000_0000, 1'b0, 1'b0, 0);
    issue(OP_SLL,  32'hFFFF_FFFF, 32'h1,       5'd31, 32'h8000_0000, 1'b0, 1'b0, 0);
    issue(OP_SRL,  32'h0,        32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0, 0);
    issue(OP_SRA,  32'h0,        32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0, 0);
    issue(OP_SRA,  32'h0,        32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b0, 1'b0, 0);
    issue(6'h3F,   32'h5,        32'h5,        5'd0,  32'h0000_0000, 1'b0, 1'b1, 0);
    issue(6'h01,   32'h5,        32'h5,        5'd0,  32'h0000_0000, 1'b0, 1'b1, 0);
    drop();
    drain();

    // mult -3 * 7 = 0xFFFFFFFF_FFFFFFEB; request stays asserted while busy and must be ignored.
    issue(OP_MULT, 32'hFFFF_FFFD, 32'h7, 5'd0, 32'hFFFF_FFEB, 1'b0, 1'b0, 32);
    ok = 1'b1;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      if (!busy || in_ready || out_valid) ok = 1'b0;
    end
    chk("busy_31_cycles_after_mult_accept", {31'd0, ok}, 32'd1);
    issue(OP_MFHI,  32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0000_0001, 1'b0, 1'b0, 32);
    issue(OP_MFHI,  32'h0, 32'h0, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 0);
    issue(OP_MFLO,  32'h0, 32'h0, 5'd0, 32'h0000_0001, 1'b0, 1'b0, 0);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'h2, 5'd0, 32'hFFFF_FFFD, 1'b0, 1'b0, 32);
    issue(OP_MFHI,  32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000, 1'b0, 1'b0, 32);
    issue(OP_MFHI,  32'h0, 32'h0, 5'd0, 32'h0000_0000, 1'b0, 1'b0, 0);
    issue(OP_DIVU,  32'h7, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    issue(OP_MFHI,  32'h0, 32'h0, 5'd0, 32'h0000_0007, 1'b0, 1'b0, 0);
    issue(OP_DIVU,  32'd100, 32'd7, 5'd0, 32'd14, 1'b0, 1'b0, 32);
    issue(OP_MFHI,  32'h0, 32'h0, 5'd0, 32'd2, 1'b0, 1'b0, 0);
    drop();
    drain();

    // Output stall: result held, no new accept while the consumer is not ready.
    @(negedge clk);
    out_ready = 1'b0;
    issue(OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 5'd0, 32'h0F0F_0F0F, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alu_op   = OP_ADD;
      a        = 32'd1;
      b        = 32'd1;
      in_valid = 1'b1;
      #1;
      chk("in_ready_low_while_stalled", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("in_ready_on_transfer", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("out_valid_cleared_after_transfer", {31'd0, out_valid}, 32'd0);
    drain();

    // Reset on the 10th divu iteration discards the op and clears HI/LO.
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd0, 32'd333, 1'b0, 1'b0, 32);
    drop();
    repeat (8) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    seen = 1'b0;
    #1;
    chk("busy_after_mid_div_reset", {31'd0, busy}, 32'd0);
    chk("out_valid_after_mid_div_reset", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after_mid_div_reset", {31'd0, in_ready}, 32'd1);
    issue(OP_MFLO, 32'h0, 32'h0, 5'd0, 32'h0000_0000, 1'b0, 1'b0, 0);
    issue(OP_MFHI, 32'h0, 32'h0, 5'd0, 32'h0000_0000, 1'b0, 1'b0, 0);
    drop();
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
